// File: rtl/seq_alu.sv
// Handshaked ALU with registered result, eq/zero/illegal flags and an
// iterative shift-add multiplier; one operation in flight at a time.
module seq_alu #(
  parameter int DATA_WIDTH  = 32,
  parameter int CTRL_WIDTH  = 4,
  parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] op1,
  input  logic [DATA_WIDTH-1:0] op2,
  input  logic [CTRL_WIDTH-1:0] ALU_ctrl,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ALUout,
  output logic                  eq,
  output logic                  zero,
  output logic                  illegal
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  localparam logic [CTRL_WIDTH-1:0] OP_ADD  = CTRL_WIDTH'(0);
  localparam logic [CTRL_WIDTH-1:0] OP_SUB  = CTRL_WIDTH'(1);
  localparam logic [CTRL_WIDTH-1:0] OP_AND  = CTRL_WIDTH'(2);
  localparam logic [CTRL_WIDTH-1:0] OP_OR   = CTRL_WIDTH'(3);
  localparam logic [CTRL_WIDTH-1:0] OP_XOR  = CTRL_WIDTH'(4);
  localparam logic [CTRL_WIDTH-1:0] OP_SLL  = CTRL_WIDTH'(5);
  localparam logic [CTRL_WIDTH-1:0] OP_SRL  = CTRL_WIDTH'(6);
  localparam logic [CTRL_WIDTH-1:0] OP_SRA  = CTRL_WIDTH'(7);
  localparam logic [CTRL_WIDTH-1:0] OP_SLT  = CTRL_WIDTH'(8);
  localparam logic [CTRL_WIDTH-1:0] OP_SLTU = CTRL_WIDTH'(9);
  localparam logic [CTRL_WIDTH-1:0] OP_MUL  = CTRL_WIDTH'(10);
  localparam logic [CTRL_WIDTH-1:0] OP_CMP  = CTRL_WIDTH'(11);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   acc;
  logic [DATA_WIDTH-1:0]   mcand;
  logic [DATA_WIDTH-1:0]   mplier;
  logic [CW-1:0]           cnt;
  logic [DATA_WIDTH-1:0]   res;
  logic                    bad;
  logic [DATA_WIDTH-1:0]   acc_next;
  logic [SHAMT_WIDTH-1:0]  shamt;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign shamt     = op2[SHAMT_WIDTH-1:0];
  assign acc_next  = mplier[0] ? acc + mcand : acc;

  always_comb begin
    res = '0;
    bad = 1'b0;
    unique case (ALU_ctrl)
      OP_ADD:  res = op1 + op2;
      OP_SUB:  res = op1 - op2;
      OP_AND:  res = op1 & op2;
      OP_OR:   res = op1 | op2;
      OP_XOR:  res = op1 ^ op2;
      OP_SLL:  res = op1 << shamt;
      OP_SRL:  res = op1 >> shamt;
      OP_SRA:  res = $signed(op1) >>> shamt;
      OP_SLT:  res = {{(DATA_WIDTH-1){1'b0}}, $signed(op1) < $signed(op2)};
      OP_SLTU: res = {{(DATA_WIDTH-1){1'b0}}, op1 < op2};
      OP_MUL:  res = '0;
      OP_CMP:  res = '0;
      default: bad = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      ALUout  <= '0;
      eq      <= 1'b0;
      zero    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            eq <= (op1 == op2);
            if (ALU_ctrl == OP_MUL) begin
              acc     <= '0;
              mcand   <= op1;
              mplier  <= op2;
              cnt     <= '0;
              illegal <= 1'b0;
              state   <= S_MUL;
            end else begin
              ALUout  <= res;
              zero    <= (res == '0);
              illegal <= bad;
              state   <= S_DONE;
            end
          end
        end
        S_MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          // fixed-length iteration: no early exit when mplier runs out
          if (cnt == LAST) begin
            ALUout <= acc_next;
            zero   <= (acc_next == '0);
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Randomised bench for seq_alu against an arithmetic reference model.
// Checks latency, handshake, hold behaviour, reset abort and results.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [3:0]  ALU_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUout;
  logic        eq;
  logic        zero;
  logic        illegal;

  int n_checks = 0;
  int n_pass   = 0;

  seq_alu dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op1      (op1),
    .op2      (op2),
    .ALU_ctrl (ALU_ctrl),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ALUout   (ALUout),
    .eq       (eq),
    .zero     (zero),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  function automatic logic [31:0] model(input logic [3:0] c,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] ext;
    logic [63:0] prod;
    int sh;
    sh = int'(b[4:0]);
    ext = {{32{a[31]}}, a};
    prod = 64'(a) * 64'(b);
    case (c)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return a << sh;
      4'd6:  return a >> sh;
      4'd7:  return 32'(ext >> sh);
      4'd8:  return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 1 : 0;
      4'd9:  return (a < b) ? 1 : 0;
      4'd10: return prod[31:0];
      default: return 0;
    endcase
  endfunction

  task automatic run_op(input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    logic [31:0] exp;
    int lat;
    exp = model(c, a, b);
    @(negedge clk);
    chk("ready_before", 32'(in_ready), 1);
    in_valid  = 1'b1;
    ALU_ctrl  = c;
    op1       = a;
    op2       = b;
    out_ready = (hold == 0);
    @(negedge clk);
    in_valid = 1'b0;
    op1      = $urandom;
    op2      = $urandom;
    chk("ready_busy", 32'(in_ready), 0);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("latency op%0d", c), lat, (c == 4'd10) ? 33 : 1);
    chk($sformatf("result op%0d", c), ALUout, exp);
    chk("eq", 32'(eq), 32'(a == b));
    chk("zero", 32'(zero), 32'(exp == 0));
    chk("illegal", 32'(illegal), 32'(c >= 4'd12));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      ALU_ctrl = 4'd0;
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_ready", 32'(in_ready), 0);
      chk("hold_result", ALUout, exp);
      chk("hold_eq", 32'(eq), 32'(a == b));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("drain_valid", 32'(out_valid), 0);
    chk("drain_ready", 32'(in_ready), 1);
  endtask

  initial begin
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op1       = '0;
    op2       = '0;
    ALU_ctrl  = '0;
    #12;
    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_out", ALUout, 0);
    chk("rst_flags", {29'd0, eq, zero, illegal}, 0);
    @(negedge clk);
    rst = 1'b0;

    run_op(4'd0, 32'd5, 32'd7, 0);
    run_op(4'd1, 32'd3, 32'd3, 0);
    run_op(4'd11, 32'd4, 32'd9, 0);
    run_op(4'd8, 32'hFFFF_FFFF, 32'd1, 0);
    run_op(4'd9, 32'hFFFF_FFFF, 32'd1, 0);
    run_op(4'd7, 32'h8000_0000, 32'h24, 0);
    run_op(4'd6, 32'h8000_0000, 32'h24, 0);
    run_op(4'd5, 32'd1, 32'd31, 0);
    run_op(4'd10, 32'h0001_0003, 32'd5, 0);
    run_op(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(4'd0, 32'hFFFF_FFFF, 32'd1, 5);

    // abort a multiply mid-flight with an asynchronous reset
    @(negedge clk);
    in_valid  = 1'b1;
    ALU_ctrl  = 4'd10;
    op1       = 32'd123;
    op2       = 32'd456;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_valid", 32'(out_valid), 0);
    chk("abort_out", ALUout, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", 32'(in_ready), 1);
    chk("abort_still_idle", 32'(out_valid), 0);
    run_op(4'd13, 32'd8, 32'd8, 0);

    for (int i = 0; i < 40; i++) begin
      c = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      if (i % 5 == 1) b = a;
      if (i % 7 == 2) a = 32'($urandom_range(0, 3));
      run_op(c, a, b, int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
